// File: rtl/ex_result_buffer.sv
// Execute-stage result buffer: W-op sign extension, two-entry skid buffer with
// registered in_ready, and a forwarding tap from the head entry.
module ex_result_buffer #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned RA_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_result,
  input  logic            in_word,
  input  logic [RA_W-1:0] in_rd,
  input  logic            in_reg_write,
  input  logic            in_mem_read,
  input  logic            in_mem_write,
  input  logic [XLEN-1:0] in_store_data,
  input  logic [2:0]      in_funct3,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [RA_W-1:0] out_rd,
  output logic            out_reg_write,
  output logic            out_mem_read,
  output logic            out_mem_write,
  output logic [XLEN-1:0] out_store_data,
  output logic [2:0]      out_funct3,
  output logic            fwd_valid,
  output logic [RA_W-1:0] fwd_rd,
  output logic [XLEN-1:0] fwd_data
);

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  typedef struct packed {
    logic [XLEN-1:0] result;
    logic [RA_W-1:0] rd;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic [XLEN-1:0] store_data;
    logic [2:0]      funct3;
  } entry_t;

  state_e state_q, state_d;
  entry_t head_q, skid_q, cap;
  logic   out_valid_q, in_ready_q, in_ready_d;
  logic   accept, pop;
  logic   load_head, load_skid, skid_to_head;

  assign accept = in_valid & in_ready_q;
  assign pop    = out_valid_q & out_ready;

  always_comb begin
    cap.result     = in_word ? {{(XLEN-32){in_result[31]}}, in_result[31:0]} : in_result;
    cap.rd         = in_rd;
    cap.reg_write  = in_reg_write & (in_rd != '0);
    cap.mem_read   = in_mem_read;
    cap.mem_write  = in_mem_write;
    cap.store_data = in_store_data;
    cap.funct3     = in_funct3;
  end

  always_comb begin
    state_d      = state_q;
    load_head    = 1'b0;
    load_skid    = 1'b0;
    skid_to_head = 1'b0;
    if (flush) begin
      // Flush beats both a same-cycle accept and pop.
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            state_d   = StOne;
            load_head = 1'b1;
          end
        end
        StOne: begin
          if (accept && pop) begin
            load_head = 1'b1;
          end else if (accept) begin
            state_d   = StFull;
            load_skid = 1'b1;
          end else if (pop) begin
            state_d = StEmpty;
          end
        end
        StFull: begin
          if (pop) begin
            state_d      = StOne;
            skid_to_head = 1'b1;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
    in_ready_d = ~flush & (state_d != StFull);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StEmpty;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      head_q      <= '0;
      skid_q      <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= (state_d != StEmpty);
      in_ready_q  <= in_ready_d;
      if (load_head) begin
        head_q <= cap;
      end else if (skid_to_head) begin
        head_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= cap;
      end
    end
  end

  assign in_ready       = in_ready_q;
  assign out_valid      = out_valid_q;
  assign out_result     = head_q.result;
  assign out_rd         = head_q.rd;
  assign out_reg_write  = head_q.reg_write;
  assign out_mem_read   = head_q.mem_read;
  assign out_mem_write  = head_q.mem_write;
  assign out_store_data = head_q.store_data;
  assign out_funct3     = head_q.funct3;

  // Loads are resolved in MEM, so their address must not be forwarded.
  assign fwd_valid = out_valid_q & head_q.reg_write & ~head_q.mem_read;
  assign fwd_rd    = head_q.rd;
  assign fwd_data  = head_q.result;

endmodule

// File: doc/ex_result_buffer.md
# ex_result_buffer

Execute-stage result buffer for the RV64 core. Captures the 64-bit `base_alu` result and its instruction metadata, applies RV64 W-op sign extension, and presents it to the MEM stage through a valid/ready handshake. A two-entry skid buffer keeps `in_ready` registered, and a forwarding tap feeds the ALU operand mux upstream.

## Interface
- `XLEN`, 64: datapath width.
- `RA_W`, 5: register-address width.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `flush` in 1: synchronous pipeline flush (branch/trap redirect).
- `in_valid` in 1: upstream entry valid.
- `in_ready` out 1: buffer can accept; registered.
- `in_result` in XLEN: `base_alu` result.
- `in_word` in 1: W-type op (ADDW/SUBW/SLLW/SRLW/SRAW/ADDIW…).
- `in_rd` in RA_W: destination register.
- `in_reg_write` in 1: writes `rd`.
- `in_mem_read` in 1: load; `in_result` is the address.
- `in_mem_write` in 1: store; `in_result` is the address.
- `in_store_data` in XLEN: rs2 value for stores.
- `in_funct3` in 3: access size/sign for MEM.
- `out_valid` out 1: head entry valid.
- `out_ready` in 1: MEM stage accepts.
- `out_result`, `out_rd`, `out_reg_write`, `out_mem_read`, `out_mem_write`, `out_store_data`, `out_funct3` out: head-entry payload, same widths as inputs.
- `fwd_valid` out 1: head entry forwardable.
- `fwd_rd` out RA_W: forwarded register address.
- `fwd_data` out XLEN: forwarded value.

## Operation
- Two entries: HEAD (drives `out_*`) and SKID. States: EMPTY (none valid), ONE (HEAD valid), FULL (both valid).
- Accept = `in_valid & in_ready`. Pop = `out_valid & out_ready`.
- Capture transform:
  - If `in_word`, stored result = `{{32{in_result[31]}}, in_result[31:0]}`; otherwise `in_result` unchanged.
  - `reg_write` is stored as `in_reg_write & (in_rd != 0)`.
- Transitions:
  - EMPTY + accept → ONE, data into HEAD.
  - ONE + accept + pop → ONE, new data into HEAD.
  - ONE + accept, no pop → FULL, data into SKID.
  - ONE + pop, no accept → EMPTY.
  - FULL + pop → ONE, SKID moves to HEAD. Accept cannot occur in FULL.
  - No accept and no pop: state holds.
- Ordering is strict FIFO; no entry is dropped or duplicated.
- `in_ready` is 0 in FULL and in the cycle after `flush`; 1 otherwise.
- Payload registers hold their value when not loaded. `out_*` payload is don't-care while `out_valid`=0 but must be stable while `out_valid`=1 and `out_ready`=0.
- Forwarding: `fwd_valid = out_valid & out_reg_write & ~out_mem_read`; `fwd_rd = out_rd`; `fwd_data = out_result`. Load data is not forwarded by this block.

## Timing
- Reset (`rst`=1 at a clock edge): state EMPTY; `out_valid`=0; all `out_*` payload = 0; `fwd_valid`=0.
- `in_ready` reads 1 after reset. Inputs are ignored in any cycle where `rst`=1.
- Latency: accept at edge N → `out_valid`=1 with that payload after edge N, provided the buffer was EMPTY (or ONE with a pop at N).
- Throughput: 1 entry/cycle sustained while `out_ready`=1.
- Stall: `out_ready` low for 1 cycle absorbs one extra entry into SKID; `in_ready` falls after that edge. First cycle `out_ready` returns high: HEAD pops, SKID → HEAD, `in_ready` rises after that edge.
- `flush` at edge N: both entries invalidated, state → EMPTY, `in_ready`=0 for cycle N+1, then 1.
  - `flush` has priority over a simultaneous accept (the entry is discarded) and over a pop (MEM must qualify its own capture with `~flush`).
- `rst` has priority over `flush` and all handshakes.
- All outputs except `fwd_*` come directly from registers. `fwd_*` is a single AND of registered signals.

## Test plan
- Single ADD: `in_result`=25, `in_rd`=3, `in_reg_write`=1, `out_ready`=1 → next cycle `out_valid`=1, `out_result`=25, `fwd_valid`=1, `fwd_rd`=3, `fwd_data`=25.
- W-op: `in_word`=1, `in_result`=0x0000_0000_8000_0000 → `out_result`=0xFFFF_FFFF_8000_0000. Same value with `in_word`=0 passes unchanged.
- Backpressure: stream 1,2,3,4 with `out_ready`=0 for two cycles from the second accept → `in_ready`=0 while FULL; outputs appear in order 1,2,3,4 with none lost or duplicated.
- rd=x0 and load: `in_rd`=0, `in_reg_write`=1 → `out_reg_write`=0, `fwd_valid`=0. Load with `in_rd`=5 → `fwd_valid`=0, `out_mem_read`=1.
- Flush in FULL state, with `in_valid`=1 in the same cycle → next cycle `out_valid`=0, `in_ready`=0; the cycle after, `in_ready`=1; the new entry was never captured.
- Reset mid-stream (FULL state, `rst`=1 for one edge) → `out_valid`=0, `out_result`=0, `in_ready`=1; the next accept emerges with 1-cycle latency.
